// File: rtl/audioport_pkg.sv
// Shared audioport constants and types used by the sample buffer and its neighbours.
package audioport_pkg;

  localparam int AUDIO_FIFO_SIZE = 60;
  localparam int AUDIO_CHANNELS  = 2;
  localparam int AUDIO_DATA_W    = 24;
  localparam int FIFO_WATERMARK  = AUDIO_FIFO_SIZE / 2;

  typedef logic [AUDIO_DATA_W-1:0] sample_t;

  // Select-field width that stays at least one bit for a single channel.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_frame_fifo_sample_ring.sv
// One channel of the audio sample buffer: circular storage with wrapping pointers and an exact count.
module sample_ring
  import audioport_pkg::*;
#(
  parameter  int DEPTH  = AUDIO_FIFO_SIZE,
  parameter  int DATA_W = AUDIO_DATA_W,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // DEPTH need not be a power of two, so wrap explicitly at the last slot.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/audio_frame_fifo.sv
// Multi-channel audio frame buffer: per-channel word writes, whole-frame pops, level/watermark and sticky error flags.
module audio_frame_fifo
  import audioport_pkg::*;
#(
  parameter  int CHANNELS  = AUDIO_CHANNELS,
  parameter  int DEPTH     = AUDIO_FIFO_SIZE,
  parameter  int DATA_W    = AUDIO_DATA_W,
  parameter  int WATERMARK = DEPTH / 2,
  localparam int CH_W      = sel_width(CHANNELS),
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_in,
  input  logic                       wr_in,
  input  logic [CH_W-1:0]            wr_ch_in,
  input  logic [DATA_W-1:0]          wr_data_in,
  input  logic                       rd_in,
  output logic [CHANNELS*DATA_W-1:0] frame_out,
  output logic                       frame_valid_out,
  output logic [LVL_W-1:0]           level_out,
  output logic                       empty_out,
  output logic                       full_out,
  output logic                       req_out,
  output logic                       underflow_out,
  output logic                       overflow_out
);

  logic [LVL_W-1:0]           counts [CHANNELS];
  logic [DATA_W-1:0]          heads  [CHANNELS];
  logic [CHANNELS-1:0]        push_vec;
  logic [CHANNELS*DATA_W-1:0] frame_now;
  logic [LVL_W-1:0]           level_now;
  logic                       full_now;
  logic                       pop_ok;
  logic                       ovf_now;

  logic [CHANNELS*DATA_W-1:0] frame_p1;
  logic                       vld_p1;
  logic [LVL_W-1:0]           level_p1;
  logic                       empty_p1;
  logic                       full_p1;
  logic                       req_p1;
  logic                       udf_p1;
  logic                       ovf_p1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ring
    sample_ring #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_ring (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr_in),
      .push      (push_vec[c]),
      .pop       (pop_ok),
      .push_data (wr_data_in),
      .count     (counts[c]),
      .head_data (heads[c])
    );
    assign frame_now[c*DATA_W +: DATA_W] = heads[c];
  end

  // Frame level is the shallowest channel; a frame exists only when every channel has a word.
  always_comb begin
    level_now = counts[0];
    full_now  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (counts[c] < level_now) level_now = counts[c];
      if (counts[c] == LVL_W'(DEPTH)) full_now = 1'b1;
    end
  end

  assign pop_ok = rd_in && !clr_in && (level_now != '0);

  // Out-of-range channel selects match no ring and vanish silently.
  always_comb begin
    push_vec = '0;
    ovf_now  = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_in && !clr_in && (wr_ch_in == CH_W'(c))) begin
        if ((counts[c] < LVL_W'(DEPTH)) || pop_ok) push_vec[c] = 1'b1;
        else                                       ovf_now     = 1'b1;
      end
    end
  end

  // ---- stage p1: registered frame, status and sticky flags ----
  always_ff @(posedge clk) begin
    if (!rst_n || clr_in) begin
      frame_p1 <= '0;
      vld_p1   <= 1'b0;
      level_p1 <= '0;
      empty_p1 <= 1'b1;
      full_p1  <= 1'b0;
      req_p1   <= 1'b1;
      udf_p1   <= 1'b0;
      ovf_p1   <= 1'b0;
    end else begin
      vld_p1 <= pop_ok;
      if (rd_in) frame_p1 <= pop_ok ? frame_now : '0;
      level_p1 <= level_now;
      empty_p1 <= (level_now == '0);
      full_p1  <= full_now;
      req_p1   <= (level_now <= LVL_W'(WATERMARK));
      udf_p1   <= udf_p1 | (rd_in && !pop_ok);
      ovf_p1   <= ovf_p1 | ovf_now;
    end
  end

  assign frame_out       = frame_p1;
  assign frame_valid_out = vld_p1;
  assign level_out       = level_p1;
  assign empty_out       = empty_p1;
  assign full_out        = full_p1;
  assign req_out         = req_p1;
  assign underflow_out   = udf_p1;
  assign overflow_out    = ovf_p1;

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Bench for audio_frame_fifo: directed scenarios plus random traffic against a queue-based frame model.
module tb_audio_frame_fifo;

  localparam int CH  = 2;
  localparam int DEP = 60;
  localparam int DW  = 24;
  localparam int WM  = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             clr_in;
  logic             wr_in;
  logic [0:0]       wr_ch_in;
  logic [DW-1:0]    wr_data_in;
  logic             rd_in;
  logic [CH*DW-1:0] frame_out;
  logic             frame_valid_out;
  logic [5:0]       level_out;
  logic             empty_out;
  logic             full_out;
  logic             req_out;
  logic             underflow_out;
  logic             overflow_out;

  audio_frame_fifo #(
    .CHANNELS  (CH),
    .DEPTH     (DEP),
    .DATA_W    (DW),
    .WATERMARK (WM)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr_in          (clr_in),
    .wr_in           (wr_in),
    .wr_ch_in        (wr_ch_in),
    .wr_data_in      (wr_data_in),
    .rd_in           (rd_in),
    .frame_out       (frame_out),
    .frame_valid_out (frame_valid_out),
    .level_out       (level_out),
    .empty_out       (empty_out),
    .full_out        (full_out),
    .req_out         (req_out),
    .underflow_out   (underflow_out),
    .overflow_out    (overflow_out)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: one queue per channel plus the expected registered outputs.
  logic [DW-1:0]    q0 [$];
  logic [DW-1:0]    q1 [$];
  logic [CH*DW-1:0] e_frame;
  logic             e_vld, e_empty, e_full, e_req, e_udf, e_ovf;
  logic [5:0]       e_level;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r_n, input logic c, input logic w, input logic ch,
                            input logic [DW-1:0] d, input logic rd);
    int lvl;
    bit popok;
    bit full;
    logic [DW-1:0] t0, t1;
    if (!r_n || c) begin
      q0.delete();
      q1.delete();
      e_frame = '0; e_vld = 1'b0; e_level = '0; e_empty = 1'b1;
      e_full = 1'b0; e_req = 1'b1; e_udf = 1'b0; e_ovf = 1'b0;
    end else begin
      lvl   = (q0.size() < q1.size()) ? q0.size() : q1.size();
      full  = (q0.size() == DEP) || (q1.size() == DEP);
      popok = rd && (lvl > 0);
      e_vld = popok;
      if (rd) begin
        if (popok) begin
          t0 = q0.pop_front();
          t1 = q1.pop_front();
          e_frame = {t1, t0};
        end else begin
          e_frame = '0;
          e_udf   = 1'b1;
        end
      end
      if (w) begin
        if (ch == 1'b0) begin
          if (q0.size() < DEP) q0.push_back(d); else e_ovf = 1'b1;
        end else begin
          if (q1.size() < DEP) q1.push_back(d); else e_ovf = 1'b1;
        end
      end
      e_level = 6'(lvl);
      e_empty = (lvl == 0);
      e_full  = full;
      e_req   = (lvl <= WM);
    end
  endtask

  task automatic step(input logic r_n, input logic c, input logic w, input logic ch,
                      input logic [DW-1:0] d, input logic rd);
    rst_n = r_n; clr_in = c; wr_in = w; wr_ch_in = ch; wr_data_in = d; rd_in = rd;
    @(posedge clk);
    model_edge(r_n, c, w, ch, d, rd);
    #1;
    check("frame",     64'(frame_out),       64'(e_frame));
    check("valid",     64'(frame_valid_out), 64'(e_vld));
    check("level",     64'(level_out),       64'(e_level));
    check("empty",     64'(empty_out),       64'(e_empty));
    check("full",      64'(full_out),        64'(e_full));
    check("req",       64'(req_out),         64'(e_req));
    check("underflow", 64'(underflow_out),   64'(e_udf));
    check("overflow",  64'(overflow_out),    64'(e_ovf));
  endtask

  task automatic idle();                                  step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0); endtask
  task automatic wr(input logic ch, input logic [DW-1:0] d); step(1'b1, 1'b0, 1'b1, ch, d, 1'b0); endtask
  task automatic pop();                                   step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1); endtask
  task automatic clr();                                   step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0); endtask

  task automatic wr_pair();
    wr(1'b0, DW'($urandom));
    wr(1'b1, DW'($urandom));
  endtask

  initial begin
    int lvl;
    int w_cnt;
    int guard;
    rst_n = 1'b0; clr_in = 1'b0; wr_in = 1'b0; wr_ch_in = 1'b0; wr_data_in = '0; rd_in = 1'b0;

    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("rst_level", 64'(level_out), 64'd0);
    check("rst_req",   64'(req_out),   64'd1);
    check("rst_empty", 64'(empty_out), 64'd1);
    idle();

    for (int n = 0; n < DEP; n++) begin
      wr(1'b0, DW'(n));
      wr(1'b1, DW'(24'h800000 + n));
    end
    idle();
    check("fill_full",  64'(full_out),  64'd1);
    check("fill_level", 64'(level_out), 64'd60);
    check("fill_req",   64'(req_out),   64'd0);

    step(1'b1, 1'b0, 1'b1, 1'b0, 24'h0ABCDE, 1'b1);
    check("wpop_frame0", 64'(frame_out), 64'({24'h800000, 24'h000000}));
    idle();
    check("wpop_no_ovf", 64'(overflow_out), 64'd0);
    wr(1'b1, 24'h80003C);
    wr(1'b0, 24'h000BAD);
    idle();
    check("ovf_set",   64'(overflow_out), 64'd1);
    check("ovf_level", 64'(level_out),    64'd60);

    for (int n = 0; n < DEP; n++) pop();
    idle();
    check("drain_empty", 64'(empty_out), 64'd1);
    pop();
    check("drain_udf", 64'(underflow_out), 64'd1);

    clr();
    for (int n = 0; n < 3; n++) wr(1'b0, DW'(24'h100 + n));
    pop();
    check("imb_frame", 64'(frame_out),       64'd0);
    check("imb_valid", 64'(frame_valid_out), 64'd0);
    for (int n = 0; n < 3; n++) wr(1'b1, DW'(24'h200 + n));
    idle();
    idle();
    check("imb_level", 64'(level_out), 64'd3);
    for (int n = 0; n < 3; n++) pop();

    clr();
    step(1'b1, 1'b0, 1'b1, 1'b0, 24'h00F00D, 1'b1);
    idle();

    clr();
    for (int n = 0; n < 30; n++) wr_pair();
    w_cnt = 30;
    guard = 0;
    while (w_cnt < 200 && guard < 5000) begin
      guard++;
      lvl = (q0.size() < q1.size()) ? q0.size() : q1.size();
      if (lvl < 27) begin
        wr_pair(); w_cnt++;
      end else if (lvl > 33) begin
        pop();
      end else begin
        case ($urandom_range(0, 2))
          0: begin wr_pair(); w_cnt++; end
          1: pop();
          default: begin
            step(1'b1, 1'b0, 1'b1, 1'b0, DW'($urandom), 1'b1);
            wr(1'b1, DW'($urandom));
            w_cnt++;
          end
        endcase
      end
    end
    check("wrap_budget", 64'(w_cnt), 64'd200);

    clr();
    pop();
    for (int n = 0; n < 17; n++) wr_pair();
    idle();
    check("clr_pre_level", 64'(level_out), 64'd17);
    step(1'b1, 1'b1, 1'b1, 1'b0, 24'h123456, 1'b1);
    check("clr_level", 64'(level_out),       64'd0);
    check("clr_udf",   64'(underflow_out),   64'd0);
    check("clr_valid", 64'(frame_valid_out), 64'd0);
    idle();

    for (int n = 0; n < 400; n++) begin
      step(1'b1, ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
